qed_trace_dump: RTL and testbench
=================================

# qed_trace_dump

Drains the two frozen QED trace buffers after a fault is latched, emitting entries oldest-first as original/duplicate pairs over a valid/ready stream for the debug host. It sits directly downstream of the dual-FIFO trace capture stage and consumes:

- its trace arrays;
- its head pointers;
- its sticky fault flag.

For every pair it flags whether the two packets differ, so the first divergence is visible without host-side diffing.

## Interface
- FIFO_SIZE, 16, entries per trace buffer; power of two, ≥2; must match the capture stage.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- trace1  in  MEM_WB_PACKET[FIFO_SIZE]  original-stream trace contents.
- trace2  in  MEM_WB_PACKET[FIFO_SIZE]  duplicate-stream trace contents.
- head1  in  $clog2(FIFO_SIZE)  next-write slot of trace1, which is the oldest entry.
- head2  in  $clog2(FIFO_SIZE)  next-write slot of trace2.
- has_fault_occured  in  1  sticky fault flag; traces are frozen while high.
- out_valid  out  1  beat available.
- out_ready  in  1  host accepts the beat.
- out_packet  out  MEM_WB_PACKET  current entry.
- out_src  out  1  0 = trace1, 1 = trace2.
- out_offset  out  $clog2(FIFO_SIZE)  age of the entry; 0 = oldest.
- out_diff  out  1  on src=1 beats: trace1 and trace2 entries at this offset differ.
- out_last  out  1  final beat of the dump.
- dump_done  out  1  sticky; dump complete.

## Operation
- State encoding is QED_DUMP_STATE with states IDLE, EMIT_A, EMIT_B, DONE.
- IDLE:
  - If has_fault_occured=1, latch base1←head1 and base2←head2, set off←0, and go to EMIT_A.
  - Otherwise remain in IDLE.
- EMIT_A:
  - out_valid=1, out_src=0, out_packet=trace1[base1+off].
  - On handshake (out_valid & out_ready), go to EMIT_B.
- EMIT_B:
  - out_valid=1, out_src=1, out_packet=trace2[base2+off].
  - out_diff=(trace1[base1+off] != trace2[base2+off]), full-packet bitwise compare.
  - On handshake: if off==FIFO_SIZE-1, go to DONE; else off←off+1 and go to EMIT_A.
- DONE:
  - out_valid=0, dump_done=1.
  - Remains in DONE until reset. A fault flag that is still high does not restart the dump.
- Index arithmetic is $clog2(FIFO_SIZE) bits, modulo FIFO_SIZE; base+off wraps naturally (e.g. base=14, off=3 → slot 1 for size 16).
- out_offset=off in both emit states.
- out_last=1 only in EMIT_B with off==FIFO_SIZE-1.
- out_diff=0 in every state other than EMIT_B.
- Bases are latched once. Changes to head1/head2 after the start are ignored.
- A deassertion of has_fault_occured mid-dump is ignored; the dump completes.
- Slots never written since reset are dumped as-is (all-zero packets). No filtering.
- Total beats per dump: 2·FIFO_SIZE.

## Timing
- Reset values:
  - state=IDLE, off=0, base1=base2=0.
  - out_valid=0, out_src=0, out_offset=0, out_diff=0, out_last=0, dump_done=0.
  - out_packet='0 whenever out_valid=0.
- Start latency: has_fault_occured sampled high at edge N; out_valid=1 from cycle N+1.
- out_packet, out_src, out_offset, out_diff and out_last are decoded from registered state, off and bases, plus the frozen trace inputs.
  - They are stable while out_valid=1 and out_ready=0.
  - No combinational path from out_ready to out_valid or to the data outputs.
- Throughput: one beat per cycle while out_ready=1.
  - A full dump with out_ready held high takes 2·FIFO_SIZE cycles after start.
  - dump_done rises on the cycle after the out_last handshake.
- Reset asserted mid-dump: the next cycle is IDLE with all outputs at reset values. A fresh dump starts only when has_fault_occured is seen high after reset.

## Structure
- Shared package (sys_defs):
  - MEM_WB_PACKET, existing.
  - New enum QED_DUMP_STATE.
  - Constant QED_TRACE_SIZE=16, used as FIFO_SIZE default by both trace stages.
- Single flat module with no sub-modules. The two read muxes and the comparator are inline.

## Test plan
All scenarios use FIFO_SIZE=4 with packets uniquely tagged.
- Basic drain:
  - Stimulus: head1=head2=0; trace1={A0..A3}, trace2=trace1; fault high at cycle 5; ready=1.
  - Response: out_valid from cycle 6; 8 beats A0,A0,A1,A1,…,A3,A3; out_diff=0 throughout; out_last on beat 8; dump_done=1 at cycle 14.
- Wrap-around:
  - Stimulus: head1=head2=3.
  - Response: order is slots 3,0,1,2; out_offset runs 0..3.
- Divergence:
  - Stimulus: trace2 slot 1 corrupted, head=0.
  - Response: out_diff=1 only on the src=1 beat with out_offset=1.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1.
  - Response: data held stable during stalls; no beat lost or duplicated; 8 handshakes total.
- Reset mid-dump:
  - Stimulus: reset after 3 beats with fault still high.
  - Response: outputs go to reset values for one cycle, then the dump restarts from offset 0.
- Sticky done:
  - Stimulus: after DONE, keep the fault high and change head1.
  - Response: out_valid stays 0 and dump_done stays 1.

Source files
------------

// File: rtl/sys_defs.sv
// Shared type definitions for the pipeline and the QED trace stages.
// Holds the MEM/WB packet, the dump FSM state enum and trace sizing.
package sys_defs;

  localparam int QED_TRACE_SIZE = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] result;
    logic [4:0]  dest_reg;
    logic        wr_en;
    logic        valid;
  } MEM_WB_PACKET;

  typedef enum logic [1:0] {
    IDLE,
    EMIT_A,
    EMIT_B,
    DONE
  } QED_DUMP_STATE;

endpackage

// File: rtl/qed_trace_dump.sv
// Drains both frozen QED trace buffers oldest-first as orig/dup pairs.
// Ports: clk/reset, trace1/2 + head1/2 + has_fault_occured in; stream out.
module qed_trace_dump
  import sys_defs::*;
#(
  parameter int FIFO_SIZE = QED_TRACE_SIZE
) (
  input  logic                         clk,
  input  logic                         reset,
  input  MEM_WB_PACKET                 trace1 [FIFO_SIZE],
  input  MEM_WB_PACKET                 trace2 [FIFO_SIZE],
  input  logic [$clog2(FIFO_SIZE)-1:0] head1,
  input  logic [$clog2(FIFO_SIZE)-1:0] head2,
  input  logic                         has_fault_occured,
  output logic                         out_valid,
  input  logic                         out_ready,
  output MEM_WB_PACKET                 out_packet,
  output logic                         out_src,
  output logic [$clog2(FIFO_SIZE)-1:0] out_offset,
  output logic                         out_diff,
  output logic                         out_last,
  output logic                         dump_done
);

  localparam int IW = $clog2(FIFO_SIZE);
  localparam logic [IW-1:0] LAST = IW'(FIFO_SIZE - 1);

  QED_DUMP_STATE state_q;
  logic [IW-1:0] off_q;
  logic [IW-1:0] base1_q;
  logic [IW-1:0] base2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      off_q   <= '0;
      base1_q <= '0;
      base2_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (has_fault_occured) begin
            base1_q <= head1;
            base2_q <= head2;
            off_q   <= '0;
            state_q <= EMIT_A;
          end
        end
        EMIT_A: begin
          if (out_ready) state_q <= EMIT_B;
        end
        EMIT_B: begin
          if (out_ready) begin
            if (off_q == LAST) begin
              state_q <= DONE;
            end else begin
              off_q   <= off_q + 1'b1;
              state_q <= EMIT_A;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Slot index wraps modulo FIFO_SIZE through IW-bit addition.
  logic [IW-1:0] idx1;
  logic [IW-1:0] idx2;
  MEM_WB_PACKET  pkt1;
  MEM_WB_PACKET  pkt2;
  logic          emit_a;
  logic          emit_b;

  assign idx1   = base1_q + off_q;
  assign idx2   = base2_q + off_q;
  assign pkt1   = trace1[idx1];
  assign pkt2   = trace2[idx2];
  assign emit_a = (state_q == EMIT_A);
  assign emit_b = (state_q == EMIT_B);

  assign out_valid  = emit_a | emit_b;
  assign out_packet = emit_a ? pkt1 : (emit_b ? pkt2 : '0);
  assign out_src    = emit_b;
  assign out_offset = out_valid ? off_q : '0;
  assign out_diff   = emit_b & (pkt1 != pkt2);
  assign out_last   = emit_b & (off_q == LAST);
  assign dump_done  = (state_q == DONE);

endmodule

// File: tb/tb_qed_trace_dump.sv
// Randomised bench for qed_trace_dump against a beat-queue reference.
// Directed scenarios pin the model with literal expectations.
module tb_qed_trace_dump;
  import sys_defs::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic         clk = 1'b0;
  logic         reset;
  MEM_WB_PACKET trace1 [N];
  MEM_WB_PACKET trace2 [N];
  logic [IW-1:0] head1, head2;
  logic         fault;
  logic         out_valid;
  logic         out_ready;
  MEM_WB_PACKET out_packet;
  logic         out_src;
  logic [IW-1:0] out_offset;
  logic         out_diff;
  logic         out_last;
  logic         dump_done;

  always #5 clk = ~clk;

  qed_trace_dump #(.FIFO_SIZE(N)) dut (
    .clk               (clk),
    .reset             (reset),
    .trace1            (trace1),
    .trace2            (trace2),
    .head1             (head1),
    .head2             (head2),
    .has_fault_occured (fault),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_packet        (out_packet),
    .out_src           (out_src),
    .out_offset        (out_offset),
    .out_diff          (out_diff),
    .out_last          (out_last),
    .dump_done         (dump_done)
  );

  typedef struct {
    MEM_WB_PACKET pkt;
    bit           src;
    int           off;
    bit           diff;
    bit           last;
  } beat_t;

  // Model: 0 = waiting for fault, 1 = dumping, 2 = finished.
  beat_t expq[$];
  int    mode;
  int    vectors;
  int    miscompares;
  int    cyc;
  int    hs_pc[$];
  int    diff_seen;

  task automatic cmp(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_pkt(input MEM_WB_PACKET act, input MEM_WB_PACKET exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL packet cycle %0d: got %0h expected %0h", cyc, act, exp);
    end
  endtask

  function automatic MEM_WB_PACKET mk(input int t);
    MEM_WB_PACKET p;
    p.pc       = 32'(t);
    p.inst     = 32'(t * 7 + 1);
    p.result   = 32'(t ^ 32'h5a5a);
    p.dest_reg = 5'(t);
    p.wr_en    = 1'b1;
    p.valid    = 1'b1;
    return p;
  endfunction

  function automatic MEM_WB_PACKET mkr();
    MEM_WB_PACKET p;
    p.pc       = $urandom;
    p.inst     = $urandom;
    p.result   = $urandom;
    p.dest_reg = 5'($urandom);
    p.wr_en    = 1'($urandom);
    p.valid    = 1'($urandom);
    return p;
  endfunction

  task automatic fill(input int base);
    for (int i = 0; i < N; i++) begin
      trace1[i] = mk(base + i);
      trace2[i] = mk(base + i);
    end
  endtask

  task automatic build();
    beat_t b;
    expq.delete();
    for (int k = 0; k < N; k++) begin
      int s1;
      int s2;
      s1 = (int'(head1) + k) % N;
      s2 = (int'(head2) + k) % N;
      b.pkt  = trace1[s1];
      b.src  = 1'b0;
      b.off  = k;
      b.diff = 1'b0;
      b.last = 1'b0;
      expq.push_back(b);
      b.pkt  = trace2[s2];
      b.src  = 1'b1;
      b.diff = (trace1[s1] != trace2[s2]);
      b.last = (k == N - 1);
      expq.push_back(b);
    end
  endtask

  task automatic check_outputs();
    MEM_WB_PACKET zero;
    zero = '0;
    if (mode == 1) begin
      cmp("valid", longint'(out_valid), 1);
      cmp_pkt(out_packet, expq[0].pkt);
      cmp("src", longint'(out_src), longint'(expq[0].src));
      cmp("offset", longint'(out_offset), longint'(expq[0].off));
      cmp("diff", longint'(out_diff), longint'(expq[0].diff));
      cmp("last", longint'(out_last), longint'(expq[0].last));
    end else begin
      cmp("valid", longint'(out_valid), 0);
      cmp_pkt(out_packet, zero);
      cmp("src", longint'(out_src), 0);
      cmp("offset", longint'(out_offset), 0);
      cmp("diff", longint'(out_diff), 0);
      cmp("last", longint'(out_last), 0);
    end
    cmp("done", longint'(dump_done), longint'(mode == 2));
  endtask

  // Drive one cycle's inputs, advance the model, check after the edge.
  task automatic step(input logic r, input logic f, input logic rdy);
    if (out_valid && rdy && !r) begin
      hs_pc.push_back(int'(out_packet.pc));
      if (out_diff) diff_seen++;
    end
    reset     = r;
    fault     = f;
    out_ready = rdy;
    if (r) begin
      mode = 0;
      expq.delete();
    end else if (mode == 0 && f) begin
      build();
      mode = 1;
    end else if (mode == 1 && rdy) begin
      void'(expq.pop_front());
      if (expq.size() == 0) mode = 2;
    end
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic run_to_done(input int pat);
    int budget;
    budget = 0;
    while (mode != 2 && budget < 60) begin
      logic rdy;
      case (pat)
        0:       rdy = 1'b1;
        1:       rdy = (budget % 4 == 0) || (budget % 4 == 3);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (pat == 2) begin
        head1 = IW'($urandom);
        head2 = IW'($urandom);
        step(1'b0, 1'($urandom), rdy);
      end else begin
        step(1'b0, 1'b1, rdy);
      end
      budget++;
    end
    cmp("dump_timeout", longint'(mode), 2);
  endtask

  initial begin
    int seq_basic [8];
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    mode        = 0;
    diff_seen   = 0;
    reset       = 1'b1;
    fault       = 1'b0;
    out_ready   = 1'b0;
    head1       = '0;
    head2       = '0;
    fill(32'hA0);
    @(negedge clk);

    // Basic drain
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    cmp("reset_done", longint'(dump_done), 0);
    cmp("reset_valid", longint'(out_valid), 0);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    hs_pc.delete();
    step(1'b0, 1'b1, 1'b1);
    cmp("start_latency", longint'(out_valid), 1);
    repeat (7) step(1'b0, 1'b1, 1'b1);
    cmp("last_on_beat8", longint'(out_last), 1);
    cmp("done_not_early", longint'(dump_done), 0);
    step(1'b0, 1'b1, 1'b1);
    cmp("done_after_last", longint'(dump_done), 1);
    seq_basic = '{32'hA0, 32'hA0, 32'hA1, 32'hA1,
                  32'hA2, 32'hA2, 32'hA3, 32'hA3};
    cmp("basic_count", longint'(hs_pc.size()), 8);
    for (int i = 0; i < 8 && i < hs_pc.size(); i++)
      cmp("basic_seq", longint'(hs_pc[i]), longint'(seq_basic[i]));

    // Wrap-around
    fill(32'hB0);
    head1 = 2'd3;
    head2 = 2'd3;
    step(1'b1, 1'b1, 1'b1);
    hs_pc.delete();
    step(1'b0, 1'b1, 1'b1);
    run_to_done(0);
    cmp("wrap_first", longint'(hs_pc.size() > 0 ? hs_pc[0] : 0), 32'hB3);
    cmp("wrap_third", longint'(hs_pc.size() > 2 ? hs_pc[2] : 0), 32'hB0);

    // Divergence
    fill(32'hC0);
    head1 = '0;
    head2 = '0;
    trace2[1].result = trace2[1].result ^ 32'h1;
    step(1'b1, 1'b0, 1'b1);
    diff_seen = 0;
    step(1'b0, 1'b1, 1'b1);
    run_to_done(0);
    cmp("diff_count", longint'(diff_seen), 1);

    // Backpressure
    fill(32'hD0);
    step(1'b1, 1'b0, 1'b1);
    hs_pc.delete();
    step(1'b0, 1'b1, 1'b0);
    run_to_done(1);
    cmp("bp_count", longint'(hs_pc.size()), 8);
    for (int i = 0; i < 8 && i < hs_pc.size(); i++)
      cmp("bp_seq", longint'(hs_pc[i]), longint'(32'hD0 + i / 2));

    // Reset mid-dump
    fill(32'hE0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    cmp("pre_reset_off", longint'(out_offset), 1);
    step(1'b1, 1'b1, 1'b1);
    cmp("mid_reset_valid", longint'(out_valid), 0);
    step(1'b0, 1'b1, 1'b1);
    cmp("restart_valid", longint'(out_valid), 1);
    cmp("restart_off", longint'(out_offset), 0);
    cmp("restart_src", longint'(out_src), 0);
    run_to_done(0);

    // Sticky done
    head1 = 2'd2;
    step(1'b0, 1'b1, 1'b1);
    head1 = 2'd1;
    step(1'b0, 1'b1, 1'b0);
    cmp("sticky_valid", longint'(out_valid), 0);
    cmp("sticky_done", longint'(dump_done), 1);

    // Randomised dumps
    for (int d = 0; d < 12; d++) begin
      for (int i = 0; i < N; i++) begin
        trace1[i] = mkr();
        trace2[i] = ($urandom_range(0, 2) == 0) ? mkr() : trace1[i];
      end
      head1 = IW'($urandom);
      head2 = ($urandom_range(0, 1) == 0) ? head1 : IW'($urandom);
      step(1'b1, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'($urandom));
      step(1'b0, 1'b1, 1'($urandom));
      run_to_done(2);
      repeat (2) step(1'b0, 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
